// File: rtl/la_capture_core_pkg.sv
// Shared trigger-mode codes and capture FSM states for the logic-analyser core.
// Imported by la_capture_core; holds no logic.
package la_pkg;
   localparam logic [2:0] LA_TRIG_RISE    = 3'd0;
   localparam logic [2:0] LA_TRIG_FALL    = 3'd1;
   localparam logic [2:0] LA_TRIG_ANY     = 3'd2;
   localparam logic [2:0] LA_TRIG_HIGH    = 3'd3;
   localparam logic [2:0] LA_TRIG_LOW     = 3'd4;
   localparam logic [2:0] LA_TRIG_PATTERN = 3'd5;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE_FILL,
      ST_ARMED,
      ST_POST,
      ST_DONE
   } la_state_t;
endpackage

// File: rtl/la_capture_core_sample_ram.sv
// Simple dual-port sample store, one write and one registered read port.
// Read data 1 cycle after address; no backpressure, write accepted every cycle.
module la_sample_ram #(
   parameter int DW = 8,
   parameter int AW = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_data
);
   logic [DW-1:0] mem [0:(1<<AW)-1];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) rd_data <= '0;
      else     rd_data <= mem[rd_addr];
   end
endmodule

// File: rtl/la_capture_core.sv
// Logic-analyser capture: synchronised probes, sample divider, trigger FSM, trigger-aligned readback.
// rd_data 1 cycle after rd_addr, no backpressure; LA_TRIG_HOLDOFF_EN adds trig_cnt trigger holdoff.
module la_capture_core
   import la_pkg::*;
#(
   parameter int  CH_NUM = 8,
   parameter int  DEPTH  = 1024,
   parameter int  DIV_W  = 6,
   localparam int AW     = $clog2(DEPTH),
   localparam int CW     = $clog2(CH_NUM)
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [CH_NUM-1:0] data_in,
   input  logic              start,
   input  logic              abort,
   input  logic              trigger_en,
   input  logic [2:0]        trig_mode,
   input  logic [CW-1:0]     trig_chn,
   input  logic [CH_NUM-1:0] trig_mask,
   input  logic [CH_NUM-1:0] trig_pattern,
   input  logic [DIV_W-1:0]  interval,
   input  logic [AW-1:0]     pre_num,
`ifdef LA_TRIG_HOLDOFF_EN
   input  logic [7:0]        trig_cnt,
`endif
   output logic              busy,
   output logic              triggered,
   output logic              finished,
   input  logic [AW-1:0]     rd_addr,
   output logic [CH_NUM-1:0] rd_data
);
   la_state_t         state, state_nxt;
   logic [CH_NUM-1:0] sync1, sync2, prev_smp, mask_l, pat_l;
   logic [DIV_W-1:0]  div_cnt, interval_l;
   logic [2:0]        mode_l;
   logic [CW-1:0]     chn_l;
   logic              ten_l, have_prev, trig_q;
   logic [AW-1:0]     pre_l, post_len, wr_ptr, smp_cnt, trig_addr, rd_phys;
   logic              run, tick, qual, fire;

   assign run      = (state == ST_PRE_FILL) || (state == ST_ARMED) || (state == ST_POST);
   assign tick     = run && (div_cnt == interval_l);
   assign post_len = AW'(DEPTH - 1) - pre_l;
   assign rd_phys  = trig_addr - pre_l + rd_addr;

   // Trigger condition on the sample being written this tick.
   always_comb begin
      qual = 1'b0;
      case (mode_l)
         LA_TRIG_RISE:    qual = have_prev && !prev_smp[chn_l] && sync2[chn_l];
         LA_TRIG_FALL:    qual = have_prev && prev_smp[chn_l] && !sync2[chn_l];
         LA_TRIG_ANY:     qual = have_prev && (prev_smp[chn_l] != sync2[chn_l]);
         LA_TRIG_HIGH:    qual = sync2[chn_l];
         LA_TRIG_LOW:     qual = !sync2[chn_l];
         LA_TRIG_PATTERN: qual = ((sync2 ^ pat_l) & mask_l) == '0;
         default:         qual = 1'b0;
      endcase
   end

`ifdef LA_TRIG_HOLDOFF_EN
   logic [7:0] hold_left;
   assign fire = !ten_l || (qual && (hold_left == 8'd0));
`else
   assign fire = !ten_l || qual;
`endif

   always_comb begin
      state_nxt = state;
      busy      = run;
      finished  = (state == ST_DONE);
      triggered = trig_q;
      case (state)
         ST_IDLE, ST_DONE: if (start) state_nxt = (pre_num == '0) ? ST_ARMED : ST_PRE_FILL;
         ST_PRE_FILL:      if (tick && (smp_cnt == pre_l - AW'(1))) state_nxt = ST_ARMED;
         ST_ARMED:         if (tick && fire) state_nxt = (post_len == '0) ? ST_DONE : ST_POST;
         ST_POST:          if (tick && (smp_cnt == post_len - AW'(1))) state_nxt = ST_DONE;
         default:          state_nxt = ST_IDLE;
      endcase
      if (abort) state_nxt = ST_IDLE;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= ST_IDLE;
         sync1      <= '0;
         sync2      <= '0;
         prev_smp   <= '0;
         mask_l     <= '0;
         pat_l      <= '0;
         div_cnt    <= '0;
         interval_l <= '0;
         mode_l     <= '0;
         chn_l      <= '0;
         ten_l      <= 1'b0;
         have_prev  <= 1'b0;
         trig_q     <= 1'b0;
         pre_l      <= '0;
         wr_ptr     <= '0;
         smp_cnt    <= '0;
         trig_addr  <= '0;
`ifdef LA_TRIG_HOLDOFF_EN
         hold_left  <= '0;
`endif
      end else begin
         state <= state_nxt;
         sync1 <= data_in;
         sync2 <= sync1;
         if (abort) begin
            trig_q <= 1'b0;
         end else if (start && !run) begin
            // An AW-bit pre_num can never exceed DEPTH-1, so it latches unclamped.
            pre_l      <= pre_num;
            interval_l <= interval;
            mode_l     <= trig_mode;
            chn_l      <= trig_chn;
            mask_l     <= trig_mask;
            pat_l      <= trig_pattern;
            ten_l      <= trigger_en;
            div_cnt    <= '0;
            wr_ptr     <= '0;
            smp_cnt    <= '0;
            have_prev  <= 1'b0;
            trig_q     <= 1'b0;
`ifdef LA_TRIG_HOLDOFF_EN
            hold_left  <= trig_cnt;
`endif
         end else if (tick) begin
            div_cnt   <= '0;
            wr_ptr    <= wr_ptr + AW'(1);
            prev_smp  <= sync2;
            have_prev <= 1'b1;
            if (state == ST_ARMED) begin
               if (fire) begin
                  trig_q    <= 1'b1;
                  trig_addr <= wr_ptr;
                  smp_cnt   <= '0;
               end
`ifdef LA_TRIG_HOLDOFF_EN
               if (ten_l && qual && (hold_left != 8'd0)) hold_left <= hold_left - 8'd1;
`endif
            end else begin
               smp_cnt <= smp_cnt + AW'(1);
            end
         end else if (run) begin
            div_cnt <= div_cnt + DIV_W'(1);
         end
      end
   end

   la_sample_ram #(.DW(CH_NUM), .AW(AW)) u_ram (
      .clk     (sys_clk),
      .rst     (sys_rst),
      .we      (tick),
      .wr_addr (wr_ptr),
      .wr_data (sync2),
      .rd_addr (rd_phys),
      .rd_data (rd_data)
   );
endmodule

// File: tb/tb_la_capture_core.sv
// Bench for la_capture_core (DEPTH=16): sample-stream reference model, per-cycle status compare, readback compare.
module tb_la_capture_core;
   localparam int DEPTH = 16;
   localparam int MAXC  = 1200;
   localparam int BIG   = 1 << 30;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [7:0] data_in = 8'h00;
   logic       start = 1'b0, abort = 1'b0, trigger_en = 1'b0;
   logic [2:0] trig_mode = 3'd0, trig_chn = 3'd0;
   logic [7:0] trig_mask = 8'h00, trig_pattern = 8'h00;
   logic [5:0] interval = 6'd0;
   logic [3:0] pre_num = 4'd0, rd_addr = 4'd0;
   logic       busy, triggered, finished;
   logic [7:0] rd_data;
`ifdef LA_TRIG_HOLDOFF_EN
   logic [7:0] trig_cnt = 8'd0;
`endif

   int tests = 0;
   int fails = 0;
   logic [7:0] stim [0:MAXC-1];

   always #5 sys_clk = ~sys_clk;

   la_capture_core #(.CH_NUM(8), .DEPTH(DEPTH), .DIV_W(6)) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .data_in      (data_in),
      .start        (start),
      .abort        (abort),
      .trigger_en   (trigger_en),
      .trig_mode    (trig_mode),
      .trig_chn     (trig_chn),
      .trig_mask    (trig_mask),
      .trig_pattern (trig_pattern),
      .interval     (interval),
      .pre_num      (pre_num),
`ifdef LA_TRIG_HOLDOFF_EN
      .trig_cnt     (trig_cnt),
`endif
      .busy         (busy),
      .triggered    (triggered),
      .finished     (finished),
      .rd_addr      (rd_addr),
      .rd_data      (rd_data)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // stim[m] is on data_in before edge m-2 (edge 0 = start), so sample j is stim[(ivl+1)*(j+1)].
   function automatic logic [7:0] samp(input int j, input int ivl);
      int m;
      m = (ivl + 1) * (j + 1);
      return (m < MAXC) ? stim[m] : 8'h00;
   endfunction

   function automatic bit qual(input int mode, input int chn, input logic [7:0] mask,
                               input logic [7:0] pat, input logic [7:0] cur,
                               input logic [7:0] prv, input bit hp);
      case (mode)
         0:       return hp && !prv[chn] && cur[chn];
         1:       return hp && prv[chn] && !cur[chn];
         2:       return hp && (prv[chn] != cur[chn]);
         3:       return cur[chn] == 1'b1;
         4:       return cur[chn] == 1'b0;
         5:       return ((cur ^ pat) & mask) == 8'h00;
         default: return 1'b0;
      endcase
   endfunction

   // Index of the trigger sample, or -1 if none within the stimulus.
   function automatic int model_trig(input int mode, input int chn, input logic [7:0] mask,
                                     input logic [7:0] pat, input int ivl, input int pre,
                                     input bit ten, input int hold, input int nsamp);
      int seen;
      seen = 0;
      if (pre >= nsamp) return -1;
      if (!ten) return pre;
      for (int j = pre; j < nsamp; j++) begin
         if (qual(mode, chn, mask, pat, samp(j, ivl), (j > 0) ? samp(j - 1, ivl) : 8'h00, j > 0)) begin
            if (seen == hold) return j;
            seen++;
         end
      end
      return -1;
   endfunction

   task automatic read_at(input int a, output logic [7:0] d);
      rd_addr = 4'(a);
      @(negedge sys_clk);
      d = rd_data;
   endtask

   task automatic capture(input int mode, input int chn, input logic [7:0] mask,
                          input logic [7:0] pat, input int ivl, input int pre,
                          input bit ten, input int hold, input int abort_at,
                          input bit xstart, input int budget,
                          output int t, output int efin);
      int et, post, nsamp, klast, xs, lim;
      post  = DEPTH - 1 - pre;
      nsamp = (MAXC - 1) / (ivl + 1);
      t     = model_trig(mode, chn, mask, pat, ivl, pre, ten, hold, nsamp);
      et    = (t >= 0) ? (ivl + 1) * (t + 1) : BIG;
      efin  = (t >= 0 && t + post < nsamp) ? (ivl + 1) * (t + post + 1) : BIG;
      if (abort_at >= 0)     klast = abort_at + 1;
      else if (efin < budget) klast = efin + 1;
      else                   klast = budget;
      xs = -1;
      if (xstart) begin
         lim = (efin - 1 < 50) ? efin - 1 : 50;
         if (abort_at > 0 && abort_at - 1 < lim) lim = abort_at - 1;
         if (lim >= 1) xs = $urandom_range(1, lim);
      end

      @(negedge sys_clk) data_in = stim[0];
      @(negedge sys_clk) data_in = stim[1];
      @(negedge sys_clk);
      data_in      = stim[2];
      start        = 1'b1;
      trig_mode    = 3'(mode);
      trig_chn     = 3'(chn);
      trig_mask    = mask;
      trig_pattern = pat;
      interval     = 6'(ivl);
      pre_num      = 4'(pre);
      trigger_en   = ten;
`ifdef LA_TRIG_HOLDOFF_EN
      trig_cnt     = 8'(hold);
`endif
      for (int k = 0; k <= klast; k++) begin
         @(negedge sys_clk);
         start = 1'b0;
         abort = 1'b0;
         if (abort_at >= 0 && k >= abort_at) begin
            chk("busy_after_abort", busy, 0);
            chk("triggered_after_abort", triggered, 0);
            chk("finished_after_abort", finished, 0);
         end else begin
            chk("busy", busy, k < efin);
            chk("triggered", triggered, k >= et);
            chk("finished", finished, k >= efin);
         end
         data_in = stim[k + 3];
         if (k + 1 == abort_at) abort = 1'b1;
         if (k + 1 == xs) start = 1'b1;
      end

      if (abort_at < 0 && efin >= budget) begin
         abort = 1'b1;
         @(negedge sys_clk);
         abort = 1'b0;
         chk("busy_cleanup_abort", busy, 0);
         chk("triggered_cleanup_abort", triggered, 0);
      end else if (abort_at < 0) begin
         for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] d;
            read_at(i, d);
            chk("readback", d, samp(t - pre + i, ivl));
         end
      end
   endtask

   initial begin
      int t, efin, ivl, pre, mode, ab;
      logic [7:0] d, v, mask;

      repeat (2) @(negedge sys_clk);
      chk("reset_busy", busy, 0);
      chk("reset_triggered", triggered, 0);
      chk("reset_finished", finished, 0);
      chk("reset_rd_data", rd_data, 0);
      sys_rst = 1'b0;
      @(negedge sys_clk);
      chk("idle_busy", busy, 0);

      // Rise on ch0 at sample 10, pre 4, interval 0.
      for (int m = 0; m < MAXC; m++) stim[m] = (m >= 11) ? 8'h01 : 8'h00;
      capture(0, 0, 8'h00, 8'h00, 0, 4, 1'b1, 0, -1, 1'b1, 200, t, efin);
      chk("t1_model_trig_idx", t, 10);
      chk("t1_model_finish_edge", efin, 22);
      read_at(4, d); chk("t1_rd4_high", d[0], 1);
      read_at(3, d); chk("t1_rd3_low", d[0], 0);

      // start and abort together: abort wins, stays idle.
      @(negedge sys_clk);
      start = 1'b1; abort = 1'b1;
      @(negedge sys_clk);
      start = 1'b0; abort = 1'b0;
      chk("sa_busy", busy, 0);
      chk("sa_finished", finished, 0);
      chk("sa_triggered", triggered, 0);
      @(negedge sys_clk);
      chk("sa_still_idle", busy, 0);

      // Free-run, interval 3, counter on data_in.
      for (int m = 0; m < MAXC; m++) stim[m] = 8'(m);
      capture(0, 0, 8'h00, 8'h00, 3, 5, 1'b0, 0, -1, 1'b0, 400, t, efin);
      read_at(0, d); chk("t2_first_sample", d, 8'd4);
      read_at(1, d); chk("t2_second_sample", d, 8'd8);

      // Maximum pre-history: trigger is the last sample, finish on trigger.
      for (int m = 0; m < MAXC; m++) stim[m] = (8'($urandom) & 8'hFB) | ((m >= 21) ? 8'h04 : 8'h00);
      capture(0, 2, 8'h00, 8'h00, 0, 15, 1'b1, 0, -1, 1'b0, 200, t, efin);
      chk("t3_model_trig_idx", t, 20);
      chk("t3_model_finish_edge", efin, 21);
      read_at(15, d); chk("t3_rd15_high", d[2], 1);
      read_at(14, d); chk("t3_rd14_low", d[2], 0);

      // Pattern: A5 matches mask 0F / pattern 05, A4 never does.
      for (int m = 0; m < MAXC; m++) stim[m] = (m >= 9) ? 8'hA5 : 8'hA4;
      capture(5, 0, 8'h0F, 8'h05, 0, 2, 1'b1, 0, -1, 1'b0, 200, t, efin);
      chk("t4_model_trig_idx", t, 8);
      for (int m = 0; m < MAXC; m++) stim[m] = 8'hA4;
      capture(5, 0, 8'h0F, 8'h05, 0, 2, 1'b1, 0, -1, 1'b0, 60, t, efin);
      chk("t4b_model_no_trig", t, 32'hFFFF_FFFF);

      // Abort while in the post-trigger window.
      for (int m = 0; m < MAXC; m++) stim[m] = (m >= 11) ? 8'h01 : 8'h00;
      capture(0, 0, 8'h00, 8'h00, 0, 4, 1'b1, 0, 14, 1'b0, 200, t, efin);

`ifdef LA_TRIG_HOLDOFF_EN
      // Rising edges on ch0 at samples 6, 9, 12; holdoff 2 fires on the third.
      for (int m = 0; m < MAXC; m++) begin
         int j;
         j = m - 1;
         stim[m] = (j == 6 || j == 7 || j == 9 || j == 10 || j >= 12) ? 8'h01 : 8'h00;
      end
      capture(0, 0, 8'h00, 8'h00, 0, 2, 1'b1, 2, -1, 1'b0, 200, t, efin);
      chk("t6_model_trig_idx", t, 12);
      read_at(2, d); chk("t6_rd2_trigger_sample", d[0], 1);
      read_at(1, d); chk("t6_rd1_before_trigger", d[0], 0);
`endif

      for (int r = 0; r < 10; r++) begin
         v = 8'($urandom);
         for (int m = 0; m < MAXC; m++) begin
            if ($urandom_range(0, 2) == 0) v = 8'($urandom);
            stim[m] = v;
         end
         ivl  = $urandom_range(0, 3);
         pre  = $urandom_range(0, 15);
         mode = $urandom_range(0, 7);
         mask = 8'($urandom) & 8'($urandom);
         ab   = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 60) : -1;
`ifdef LA_TRIG_HOLDOFF_EN
         capture(mode, $urandom_range(0, 7), mask, 8'($urandom), ivl, pre,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2), ab, 1'b1, MAXC - 4, t, efin);
`else
         capture(mode, $urandom_range(0, 7), mask, 8'($urandom), ivl, pre,
                 $urandom_range(0, 3) != 0, 0, ab, 1'b1, MAXC - 4, t, efin);
`endif
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
